// File: rtl/decode_stage_pkg.sv
// +--------------------------------------------------------------------+
// | decode_stage_pkg                                                   |
// | Shared RV32I decode constants, ALU encoding and ID/EX word type.   |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

package decode_stage_pkg;

  localparam int XLEN = 32;
  localparam logic [31:0] NOP_INST = 32'h00000013;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  localparam logic [3:0] ALU_ADD   = 4'd0;
  localparam logic [3:0] ALU_SUB   = 4'd1;
  localparam logic [3:0] ALU_SLL   = 4'd2;
  localparam logic [3:0] ALU_SLT   = 4'd3;
  localparam logic [3:0] ALU_SLTU  = 4'd4;
  localparam logic [3:0] ALU_XOR   = 4'd5;
  localparam logic [3:0] ALU_SRL   = 4'd6;
  localparam logic [3:0] ALU_SRA   = 4'd7;
  localparam logic [3:0] ALU_OR    = 4'd8;
  localparam logic [3:0] ALU_AND   = 4'd9;
  localparam logic [3:0] ALU_PASSB = 4'd10;

  typedef enum logic [2:0] {
    IMM_NONE, IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
  } imm_type_e;

  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [4:0]      rd;
    logic [3:0]      alu_op;
    logic            alu_src;
    logic            reg_write;
    logic            mem_read;
    logic            mem_write;
    logic            branch;
    logic            jump;
    logic [2:0]      funct3;
    logic            illegal;
  } id_ex_t;

  function automatic imm_type_e imm_type_of(input logic [6:0] opc);
    case (opc)
      OPC_JALR, OPC_LOAD, OPC_OP_IMM: imm_type_of = IMM_I;
      OPC_STORE:                      imm_type_of = IMM_S;
      OPC_BRANCH:                     imm_type_of = IMM_B;
      OPC_LUI, OPC_AUIPC:             imm_type_of = IMM_U;
      OPC_JAL:                        imm_type_of = IMM_J;
      default:                        imm_type_of = IMM_NONE;
    endcase
  endfunction

  // Immediate forms never use SUB; only register-register bit 30 selects it.
  function automatic logic [3:0] alu_op_of(input logic [2:0] f3, input logic bit30,
                                           input logic is_imm);
    case (f3)
      3'b000:  alu_op_of = (bit30 && !is_imm) ? ALU_SUB : ALU_ADD;
      3'b001:  alu_op_of = ALU_SLL;
      3'b010:  alu_op_of = ALU_SLT;
      3'b011:  alu_op_of = ALU_SLTU;
      3'b100:  alu_op_of = ALU_XOR;
      3'b101:  alu_op_of = bit30 ? ALU_SRA : ALU_SRL;
      3'b110:  alu_op_of = ALU_OR;
      default: alu_op_of = ALU_AND;
    endcase
  endfunction

endpackage

`default_nettype wire

// File: rtl/decode_stage_imm_gen.sv
// +--------------------------------------------------------------------+
// | decode_stage_imm_gen                                               |
// | Combinational RV32I immediate extractor, sign-extended from bit 31.|
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module decode_stage_imm_gen
  import decode_stage_pkg::*;
(
  input  logic [31:0]     inst,
  output logic [XLEN-1:0] imm
);

  always_comb begin
    case (imm_type_of(inst[6:0]))
      IMM_I:   imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S:   imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B:   imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U:   imm = {inst[31:12], 12'b0};
      IMM_J:   imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/decode_stage.sv
// +--------------------------------------------------------------------+
// | decode_stage                                                       |
// | RV32I decode: control, operands with WB bypass, load-use stall.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
`default_nettype none

module decode_stage
  import decode_stage_pkg::*;
(
  input  logic        Clk_In,
  input  logic        Rst_n_In,
  input  logic [31:0] Inst_In,
  input  logic        Inst_Valid_In,
  input  logic [31:0] PC_In,
  input  logic        Flush_In,
  output logic [4:0]  RS1_Addr_Out,
  output logic [4:0]  RS2_Addr_Out,
  input  logic [31:0] RS1_Data_In,
  input  logic [31:0] RS2_Data_In,
  input  logic        WB_Reg_Write_In,
  input  logic [4:0]  WB_RD_Addr_In,
  input  logic [31:0] WB_RD_Data_In,
  output logic        Stall_Out,
  output logic        Ex_Valid_Out,
  output logic [31:0] Ex_PC_Out,
  output logic [31:0] Ex_RS1_Data_Out,
  output logic [31:0] Ex_RS2_Data_Out,
  output logic [31:0] Ex_Imm_Out,
  output logic [4:0]  Ex_RD_Addr_Out,
  output logic [3:0]  Ex_ALU_Op_Out,
  output logic        Ex_ALU_Src_Out,
  output logic        Ex_Reg_Write_Out,
  output logic        Ex_Mem_Read_Out,
  output logic        Ex_Mem_Write_Out,
  output logic        Ex_Branch_Out,
  output logic        Ex_Jump_Out,
  output logic [2:0]  Ex_Funct3_Out,
  output logic        Ex_Illegal_Out
);

  logic [31:0]     dec_inst;
  logic [XLEN-1:0] imm;
  logic [4:0]      rs1, rs2, rd;
  logic            use_rs1, use_rs2, writes_rd, hazard;
  logic [3:0]      alu_op;
  logic            alu_src, mem_read, mem_write, branch, jump, illegal;
  id_ex_t          ex_d, ex_q;

  // Idle slots decode as a NOP so the decoder and hazard logic stay quiet.
  assign dec_inst = Inst_Valid_In ? Inst_In : NOP_INST;
  assign rs1      = dec_inst[19:15];
  assign rs2      = dec_inst[24:20];
  assign rd       = dec_inst[11:7];

  assign RS1_Addr_Out = Inst_In[19:15];
  assign RS2_Addr_Out = Inst_In[24:20];

  decode_stage_imm_gen u_imm_gen (
    .inst (dec_inst),
    .imm  (imm)
  );

  always_comb begin
    alu_op    = ALU_ADD;
    alu_src   = 1'b0;
    writes_rd = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    branch    = 1'b0;
    jump      = 1'b0;
    illegal   = 1'b0;
    use_rs1   = 1'b0;
    use_rs2   = 1'b0;
    case (dec_inst[6:0])
      OPC_LUI:    begin alu_op = ALU_PASSB; alu_src = 1'b1; writes_rd = 1'b1; end
      OPC_AUIPC:  begin alu_src = 1'b1; writes_rd = 1'b1; end
      OPC_JAL:    begin alu_src = 1'b1; writes_rd = 1'b1; jump = 1'b1; end
      OPC_JALR:   begin alu_src = 1'b1; writes_rd = 1'b1; jump = 1'b1; use_rs1 = 1'b1; end
      OPC_BRANCH: begin alu_op = ALU_SUB; branch = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_LOAD:   begin alu_src = 1'b1; writes_rd = 1'b1; mem_read = 1'b1; use_rs1 = 1'b1; end
      OPC_STORE:  begin alu_src = 1'b1; mem_write = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; end
      OPC_OP_IMM: begin
        alu_op    = alu_op_of(dec_inst[14:12], dec_inst[30], 1'b1);
        alu_src   = 1'b1;
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
      end
      OPC_OP: begin
        alu_op    = alu_op_of(dec_inst[14:12], dec_inst[30], 1'b0);
        writes_rd = 1'b1;
        use_rs1   = 1'b1;
        use_rs2   = 1'b1;
      end
      default:    illegal = 1'b1;
    endcase
  end

  function automatic logic [XLEN-1:0] operand(input logic used, input logic [4:0] addr,
                                              input logic [XLEN-1:0] rf_data);
    if (!used || addr == 5'd0)
      operand = '0;
    else if (WB_Reg_Write_In && WB_RD_Addr_In == addr)
      operand = WB_RD_Data_In;
    else
      operand = rf_data;
  endfunction

  always_comb begin
    ex_d           = '0;
    ex_d.valid     = 1'b1;
    ex_d.pc        = PC_In;
    ex_d.rs1_data  = operand(use_rs1, rs1, RS1_Data_In);
    ex_d.rs2_data  = operand(use_rs2, rs2, RS2_Data_In);
    ex_d.imm       = imm;
    ex_d.rd        = writes_rd ? rd : 5'd0;
    ex_d.alu_op    = alu_op;
    ex_d.alu_src   = alu_src;
    ex_d.reg_write = writes_rd && (rd != 5'd0);
    ex_d.mem_read  = mem_read;
    ex_d.mem_write = mem_write;
    ex_d.branch    = branch;
    ex_d.jump      = jump;
    ex_d.funct3    = dec_inst[14:12];
    ex_d.illegal   = illegal;
  end

  assign hazard = ex_q.valid && ex_q.mem_read && (ex_q.rd != 5'd0) &&
                  ((use_rs1 && rs1 == ex_q.rd) || (use_rs2 && rs2 == ex_q.rd));
  assign Stall_Out = hazard && Inst_Valid_In && !Flush_In;

  always_ff @(posedge Clk_In or negedge Rst_n_In) begin
    if (!Rst_n_In)
      ex_q <= '0;
    else if (Flush_In || Stall_Out || !Inst_Valid_In)
      ex_q <= '0;
    else
      ex_q <= ex_d;
  end

  assign Ex_Valid_Out     = ex_q.valid;
  assign Ex_PC_Out        = ex_q.pc;
  assign Ex_RS1_Data_Out  = ex_q.rs1_data;
  assign Ex_RS2_Data_Out  = ex_q.rs2_data;
  assign Ex_Imm_Out       = ex_q.imm;
  assign Ex_RD_Addr_Out   = ex_q.rd;
  assign Ex_ALU_Op_Out    = ex_q.alu_op;
  assign Ex_ALU_Src_Out   = ex_q.alu_src;
  assign Ex_Reg_Write_Out = ex_q.reg_write;
  assign Ex_Mem_Read_Out  = ex_q.mem_read;
  assign Ex_Mem_Write_Out = ex_q.mem_write;
  assign Ex_Branch_Out    = ex_q.branch;
  assign Ex_Jump_Out      = ex_q.jump;
  assign Ex_Funct3_Out    = ex_q.funct3;
  assign Ex_Illegal_Out   = ex_q.illegal;

endmodule

`default_nettype wire

// File: doc/decode_stage.md
# decode_stage

Instruction-decode stage of the RV32I pipeline, between the IF/ID latch and the execute stage. It drives the register-file read addresses combinationally and captures the returned operands. It also captures the decoded control word and the sign-extended immediate into the ID/EX pipeline register. It detects load-use hazards (stall plus bubble), honours branch flushes, and bypasses the same-cycle write-back value around the register file.

## Interface
- XLEN, 32, datapath width
- NOP_INST, 32'h00000013, canonical bubble instruction (addi x0,x0,0)
- Clk_In  in  1  pipeline clock, rising edge
- Rst_n_In  in  1  reset, asynchronous, active-low
- Inst_In  in  32  instruction from IF/ID
- Inst_Valid_In  in  1  Inst_In holds a real instruction
- PC_In  in  32  PC of Inst_In
- Flush_In  in  1  taken branch/jump resolved in EX; kill the instruction in decode
- RS1_Addr_Out, RS2_Addr_Out  out  5  combinational Inst_In[19:15], Inst_In[24:20] to the register file
- RS1_Data_In, RS2_Data_In  in  32  asynchronous-read register-file data
- WB_Reg_Write_In  in  1  write-back stage writes this cycle
- WB_RD_Addr_In  in  5  write-back destination
- WB_RD_Data_In  in  32  write-back data
- Stall_Out  out  1  hold PC and IF/ID this cycle
- Ex_Valid_Out  out  1  ID/EX holds a real instruction
- Ex_PC_Out, Ex_RS1_Data_Out, Ex_RS2_Data_Out, Ex_Imm_Out  out  32  ID/EX operands
- Ex_RD_Addr_Out  out  5  destination register
- Ex_ALU_Op_Out  out  4  ALU operation code (package encoding)
- Ex_ALU_Src_Out  out  1  1 = operand B is the immediate
- Ex_Reg_Write_Out, Ex_Mem_Read_Out, Ex_Mem_Write_Out, Ex_Branch_Out, Ex_Jump_Out  out  1  control bits
- Ex_Funct3_Out  out  3  for branch compare and load/store size
- Ex_Illegal_Out  out  1  unrecognised opcode was decoded

## Operation
- Supported opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP-IMM, OP.
- Anything else sets Ex_Illegal_Out=1 with all write and memory controls 0.
- Immediate formats I/S/B/U/J are decoded and sign-extended from bit 31.
- Immediate for OP and illegal instructions = 0.
- rs1 is used by JALR, BRANCH, LOAD, STORE, OP-IMM, OP. rs2 is used by BRANCH, STORE, OP.
- Only used sources participate in hazard and bypass checks.
- Bypass: if WB_Reg_Write_In and WB_RD_Addr_In ≠ 0 and WB_RD_Addr_In equals the source address, the operand is WB_RD_Data_In; otherwise it is the register-file data.
- Operands from x0 are always 0.
- Ex_Reg_Write_Out is forced 0 when rd = 0, and for STORE and BRANCH.
- Load-use hazard condition: Ex_Valid_Out & Ex_Mem_Read_Out & Ex_RD_Addr_Out ≠ 0 & Ex_RD_Addr_Out matches a used source.
  - Stall_Out = hazard & Inst_Valid_In & !Flush_In.
- Bubble: Ex_Valid_Out=0, all control bits 0, Ex_RD_Addr_Out=0, data fields don't-care (driven 0).
- Per-edge update priority:
  1. Flush_In: bubble.
  2. Stall_Out: bubble; the instruction is re-presented by IF/ID the next cycle.
  3. !Inst_Valid_In: bubble.
  4. Otherwise: capture the decoded instruction.
- Flush has priority over stall; no stall is raised during a flush.
- The ALU code for LUI is PASSB; for AUIPC, JAL, JALR, LOAD, STORE it is ADD.
- Branches use SUB; EX evaluates the condition from Ex_Funct3_Out.

## Timing
- RS*_Addr_Out and Stall_Out are combinational (same cycle as Inst_In). Ex_* outputs have 1-cycle latency.
- A load-use stall lasts exactly one cycle, because the inserted bubble clears the condition.
- A back-to-back dependent ALU instruction needs no stall; EX forwarding covers it.
- Reset (asynchronous, any time, including mid-stall): every Ex_* output = 0, therefore Stall_Out = 0.
- Reset release: first capture happens on the first rising edge with Rst_n_In = 1.
- A WB write and a decode read of the same register in the same cycle return the new data.

## Structure
- Shared package holds:
  - opcode constants
  - ALU op encoding: ADD=0, SUB=1, SLL=2, SLT=3, SLTU=4, XOR=5, SRL=6, SRA=7, OR=8, AND=9, PASSB=10
  - immediate-type enum
  - NOP_INST
- Sub-module imm_gen is purely combinational: instruction in, 32-bit immediate out.
- The ID/EX register, hazard detection and bypass muxes live in decode_stage.

## Test plan
- Reset with Rst_n_In low mid-stream -> all Ex_* = 0 immediately and Stall_Out = 0.
- addi x1,x0,5 (0x00500093) -> next cycle:
  - Ex_Valid=1, Ex_RD=1, Ex_Imm=5
  - Ex_ALU_Src=1, Ex_ALU_Op=ADD, Ex_Reg_Write=1
- lw x2,0(x1) (0x0000A103), then add x3,x2,x2 (0x002101B3) ->
  - Stall_Out=1 for one cycle; one bubble enters EX
  - add is captured the following cycle; Stall_Out=0
- WB writes x5=0xDEADBEEF while decode reads rs1=x5 with the register file returning 0 -> Ex_RS1_Data_Out=0xDEADBEEF.
- beq x0,x0,-8 (0xFE000CE3) -> Ex_Imm=0xFFFFFFF8, Ex_Branch=1, Ex_Reg_Write=0.
- Load-use hazard with Flush_In=1 in the same cycle -> Stall_Out=0, bubble captured.
- Opcode 0x0000007F -> Ex_Illegal=1 with all write and memory controls 0.
